uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-level command parser between the UART receiver and the video/LED pipeline. It takes the receiver's byte stream (data byte plus one-cycle done strobe) and assembles fixed 5-byte frames. It verifies each frame's checksum and drives registered control fields: pattern mode for the colour-bar generator, brightness, and active LED count for the LED control stage. Bad or stalled frames are discarded and flagged; the control registers are never left partially updated.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between bytes of one frame before the frame is abandoned
- HEADER, 8'hA5: frame start byte
- MAX_LEDS, 60: upper clamp for led_count

Ports:
- clk  in  1  pixel clock, shared with the UART receiver
- rst_n  in  1  asynchronous active-low reset
- uart_done  in  1  one-cycle strobe: uart_data holds a new byte
- uart_data  in  8  received byte, valid when uart_done=1
- mode  out  8  pattern mode, reset 8'h00
- brightness  out  8  global LED brightness, reset 8'hFF
- led_count  out  8  active LED count, reset MAX_LEDS
- cmd_valid  out  1  one-cycle pulse when a frame is accepted, reset 0
- err  out  1  one-cycle pulse when a frame is rejected, reset 0
- err_code  out  2  cause of the last err (1 checksum, 2 unknown cmd, 3 timeout), held until next err, reset 0
- busy  out  1  high while state≠IDLE, reset 0

## Operation
- Frame: HEADER, CMD, D_HI, D_LO, CSUM; CSUM = (CMD + D_HI + D_LO) mod 256, 8-bit wraparound.
- States: IDLE → CMD → DHI → DLO → CSUM → IDLE. Each transition is taken only on uart_done.
- IDLE: a byte equal to HEADER moves to CMD. Any other byte is silently dropped (no err).
- CMD/DHI/DLO: latch the byte into cmd_r/dhi_r/dlo_r. A HEADER value here is ordinary data; there is no mid-frame resync.
- CSUM state, byte received:
  - Mismatch → err, err_code=1, no register change.
  - Match, cmd_r=8'h01 → mode←dlo_r.
  - Match, cmd_r=8'h02 → brightness←dlo_r.
  - Match, cmd_r=8'h03 → led_count←clamp(dlo_r): 0→1, >MAX_LEDS→MAX_LEDS, else dlo_r.
  - Match, any other cmd_r → err, err_code=2, no register change.
  - Every outcome returns to IDLE. cmd_valid pulses only for commands 01–03.
- D_HI is checksummed but reserved. It is ignored for commands 01–03.
- Timeout counter:
  - Cleared in IDLE and on every uart_done.
  - Increments each cycle while state≠IDLE.
  - On reaching TIMEOUT_CYCLES-1 without uart_done: state→IDLE, err pulse, err_code=3, partial frame discarded.
- Counter width is $clog2(TIMEOUT_CYCLES)+1. It does not wrap.

## Timing
- All outputs are registered.
- mode/brightness/led_count and cmd_valid/err update on the clock edge after the cycle in which the CSUM byte's uart_done is high (1-cycle latency).
- A byte may arrive on the cycle immediately after the CSUM byte. In that cycle the FSM is already in IDLE and accepts a new HEADER.
- Timeout and uart_done in the same cycle: the byte wins. It is processed normally, the counter is cleared, and there is no timeout err.
- cmd_valid and err are never high together.
- Reset asserted mid-frame: all outputs take their reset values asynchronously and state→IDLE. The first frame after deassertion must start with HEADER.
- uart_data is sampled only when uart_done=1. The block has no backpressure.

## Test plan
- Reset values: assert rst_n=0, release → mode=00, brightness=FF, led_count=60, cmd_valid=err=busy=0, err_code=0.
- Set mode: send A5 01 00 03 04 → mode=03 one cycle after the last done, single cmd_valid pulse, other registers unchanged.
- Checksum error: send A5 02 00 80 00 → err pulse, err_code=1, brightness stays FF. Then send A5 02 00 80 82 → brightness=80.
- Clamp and unknown cmd:
  - A5 03 00 C8 CB → led_count=60.
  - A5 03 00 00 03 → led_count=1.
  - A5 07 00 01 08 → err, err_code=2.
- Timeout with TIMEOUT_CYCLES=100: send A5 01, then stall 100 cycles → err, err_code=3, busy=0. Then send A5 01 00 05 06 → mode=05.
- Noise and boundary:
  - Send 00 FF A5 01 00 02 03 → the leading bytes are ignored without err, mode=02.
  - uart_done on exactly the expiry cycle → no timeout.
  - rst_n pulse after A5 01 00 → outputs reset, next full frame accepted.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (HEADER, CMD, D_HI, D_LO, CSUM) from the UART byte stream.
// Valid frames update the mode, brightness or LED-count registers. Bad or stalled frames pulse err.
module uart_cmd_parser #(
    parameter int           TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]   HEADER         = 8'hA5,
    parameter int           MAX_LEDS       = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    output logic [7:0] mode,
    output logic [7:0] brightness,
    output logic [7:0] led_count,
    output logic       cmd_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MAX_LEDS_B = 8'(MAX_LEDS);

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_CMD     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DHI,
        ST_DLO,
        ST_CSUM
    } state_t;

    state_t        state;
    logic [7:0]    cmd_r;
    logic [7:0]    dhi_r;
    logic [7:0]    dlo_r;
    logic [CW-1:0] cnt;
    logic [7:0]    csum_calc;
    logic [7:0]    led_clamped;

    assign csum_calc = cmd_r + dhi_r + dlo_r;

    always_comb begin
        if (dlo_r == 8'd0)
            led_clamped = 8'd1;
        else if (dlo_r > MAX_LEDS_B)
            led_clamped = MAX_LEDS_B;
        else
            led_clamped = dlo_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_r      <= 8'h00;
            dhi_r      <= 8'h00;
            dlo_r      <= 8'h00;
            cnt        <= '0;
            mode       <= 8'h00;
            brightness <= 8'hFF;
            led_count  <= MAX_LEDS_B;
            cmd_valid  <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            busy       <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each outcome below only has to raise its own.
            cmd_valid <= 1'b0;
            err       <= 1'b0;

            if (state == ST_IDLE) begin
                cnt <= '0;
                if (uart_done && uart_data == HEADER) begin
                    state <= ST_CMD;
                    busy  <= 1'b1;
                end
            end else if (uart_done) begin
                // A byte arriving on the expiry cycle wins over the timeout.
                cnt <= '0;
                case (state)
                    ST_CMD: begin
                        cmd_r <= uart_data;
                        state <= ST_DHI;
                    end
                    ST_DHI: begin
                        dhi_r <= uart_data;
                        state <= ST_DLO;
                    end
                    ST_DLO: begin
                        dlo_r <= uart_data;
                        state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (csum_calc != uart_data) begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end else begin
                            case (cmd_r)
                                8'h01: begin
                                    mode      <= dlo_r;
                                    cmd_valid <= 1'b1;
                                end
                                8'h02: begin
                                    brightness <= dlo_r;
                                    cmd_valid  <= 1'b1;
                                end
                                8'h03: begin
                                    led_count <= led_clamped;
                                    cmd_valid <= 1'b1;
                                end
                                default: begin
                                    err      <= 1'b1;
                                    err_code <= ERR_CMD;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (cnt == CNT_LAST) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                cnt      <= '0;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short timeout: frames, checksum/cmd errors,
// clamping, timeout and its boundary, leading noise and a mid-frame reset.
module tb_uart_cmd_parser;

    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic       uart_done;
    logic [7:0] uart_data;
    logic [7:0] mode;
    logic [7:0] brightness;
    logic [7:0] led_count;
    logic       cmd_valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .HEADER        (8'hA5),
        .MAX_LEDS      (60)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_done (uart_done),
        .uart_data (uart_data),
        .mode      (mode),
        .brightness(brightness),
        .led_count (led_count),
        .cmd_valid (cmd_valid),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        uart_done = 1'b1;
        uart_data = b;
        @(posedge clk);
        #1;
        uart_done = 1'b0;
        uart_data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] s);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        send_byte(s);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int waited;

        rst_n     = 1'b0;
        uart_done = 1'b0;
        uart_data = 8'h00;
        #23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_mode", mode, 8'h00);
        check("rst_bright", brightness, 8'hFF);
        check("rst_leds", led_count, 8'd60);
        check("rst_cv", cmd_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'd0);
        check("rst_busy", busy, 1'b0);

        // Set mode
        send_byte(8'hA5);
        check("hdr_busy", busy, 1'b1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h04);
        check("mode_val", mode, 8'h03);
        check("mode_cv", cmd_valid, 1'b1);
        check("mode_err", err, 1'b0);
        check("mode_busy", busy, 1'b0);
        check("mode_bright", brightness, 8'hFF);
        check("mode_leds", led_count, 8'd60);
        idle_cycles(1);
        check("mode_cv_pulse", cmd_valid, 1'b0);

        // Checksum error, then the corrected frame back to back
        send_frame(8'h02, 8'h00, 8'h80, 8'h00);
        check("csum_err", err, 1'b1);
        check("csum_code", err_code, 2'd1);
        check("csum_cv", cmd_valid, 1'b0);
        check("csum_bright", brightness, 8'hFF);
        send_frame(8'h02, 8'h00, 8'h80, 8'h82);
        check("bright_val", brightness, 8'h80);
        check("bright_cv", cmd_valid, 1'b1);
        check("bright_code_held", err_code, 2'd1);
        idle_cycles(1);
        check("err_pulse", err, 1'b0);

        // LED clamp high, clamp low, unknown command
        send_frame(8'h03, 8'h00, 8'hC8, 8'hCB);
        check("clamp_hi", led_count, 8'd60);
        check("clamp_hi_cv", cmd_valid, 1'b1);
        send_frame(8'h03, 8'h00, 8'h00, 8'h03);
        check("clamp_lo", led_count, 8'd1);
        send_frame(8'h07, 8'h00, 8'h01, 8'h08);
        check("unk_err", err, 1'b1);
        check("unk_code", err_code, 2'd2);
        check("unk_cv", cmd_valid, 1'b0);
        check("unk_leds", led_count, 8'd1);
        check("unk_mode", mode, 8'h03);

        // Timeout after A5 01
        send_byte(8'hA5);
        send_byte(8'h01);
        waited = 0;
        while (!err && waited < 3 * TIMEOUT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("to_latency", waited, TIMEOUT);
        check("to_err", err, 1'b1);
        check("to_code", err_code, 2'd3);
        check("to_busy", busy, 1'b0);
        send_frame(8'h01, 8'h00, 8'h05, 8'h06);
        check("to_recover", mode, 8'h05);

        // Leading noise is dropped silently
        send_byte(8'h00);
        check("noise0_err", err, 1'b0);
        send_byte(8'hFF);
        check("noise1_err", err, 1'b0);
        check("noise_busy", busy, 1'b0);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);
        check("noise_mode", mode, 8'h02);

        // Byte on the exact expiry cycle beats the timeout
        send_byte(8'hA5);
        send_byte(8'h01);
        idle_cycles(TIMEOUT - 1);
        check("exp_pre_busy", busy, 1'b1);
        send_byte(8'h00);
        check("exp_err", err, 1'b0);
        check("exp_busy", busy, 1'b1);
        send_byte(8'h07);
        send_byte(8'h08);
        check("exp_mode", mode, 8'h07);
        check("exp_cv", cmd_valid, 1'b1);
        check("exp_code", err_code, 2'd3);

        // Mid-frame reset
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        rst_n = 1'b0;
        #2;
        check("mrst_mode", mode, 8'h00);
        check("mrst_bright", brightness, 8'hFF);
        check("mrst_leds", led_count, 8'd60);
        check("mrst_code", err_code, 2'd0);
        check("mrst_busy", busy, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h02, 8'h00, 8'h40, 8'h42);
        check("post_rst_bright", brightness, 8'h40);
        check("post_rst_cv", cmd_valid, 1'b1);
        check("post_rst_mode", mode, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
